// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage and the units that observe it
// (hazard detection, writeback).
package mem_access_stage_pkg;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 256;
   localparam int ADDR_W = 8;

   // EX/MEM pipeline register contents
   typedef struct packed {
      logic              valid;
      logic [4:0]        rd;
      logic              mem_read;
      logic              mem_write;
      logic              reg_write;
      logic              oob;
      logic [DATA_W-1:0] result;
      logic [DATA_W-1:0] store_data;
   } exmem_t;

   // MEM/WB pipeline register contents
   typedef struct packed {
      logic              valid;
      logic              reg_write;
      logic [4:0]        rd;
      logic [DATA_W-1:0] data;
   } memwb_t;

endpackage

// File: rtl/mem_access_stage_data_mem.sv
// Word-addressed data memory: asynchronous read, synchronous write, no reset.
module mem_access_stage_data_mem
   import mem_access_stage_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port: one word per clock when enabled
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: EX/MEM register, data memory access with
// out-of-bound suppression, sticky fault latch, and MEM/WB register.
module mem_access_stage
   import mem_access_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              ex_valid,
   input  logic [DATA_W-1:0] ex_result,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic [4:0]        ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic              ex_reg_write,
   input  logic              ex_oob,
   input  logic              fault_clr,
   output logic [4:0]        mem_rd,
   output logic              mem_reg_write,
   output logic              mem_load_pending,
   output logic              wb_valid,
   output logic              wb_reg_write,
   output logic [4:0]        wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              fault,
   output logic [DATA_W-1:0] fault_addr
);

   exmem_t            exmem_p1;
   memwb_t            memwb_p2;
   memwb_t            memwb_d;
   logic              mem_op;
   logic              access_ok;
   logic              fault_set;
   logic              mem_we;
   logic [DATA_W-1:0] rdata;

   // EX -> MEM boundary: flush wins over stall so a squashed slot never survives
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         exmem_p1 <= '0;
      else if (flush)
         exmem_p1 <= '0;
      else if (!stall) begin
         exmem_p1.valid      <= ex_valid;
         exmem_p1.rd         <= ex_rd;
         exmem_p1.mem_read   <= ex_mem_read;
         exmem_p1.mem_write  <= ex_mem_write;
         exmem_p1.reg_write  <= ex_reg_write;
         exmem_p1.oob        <= ex_oob;
         exmem_p1.result     <= ex_result;
         exmem_p1.store_data <= ex_store_data;
      end
   end

   assign mem_op    = exmem_p1.valid & (exmem_p1.mem_read | exmem_p1.mem_write);
   assign access_ok = mem_op & ~exmem_p1.oob;
   assign fault_set = mem_op & exmem_p1.oob;
   // A write is committed on the edge that ends the MEM cycle, never while stalled
   assign mem_we    = access_ok & exmem_p1.mem_write & ~stall;

   mem_access_stage_data_mem u_data_mem (
      .clk   (clk),
      .we    (mem_we),
      .addr  (exmem_p1.result[ADDR_W-1:0]),
      .wdata (exmem_p1.store_data),
      .rdata (rdata)
   );

   // Result selection for writeback; stores (including read+write) never write a register
   always_comb begin
      memwb_d.valid     = exmem_p1.valid;
      memwb_d.rd        = exmem_p1.rd;
      memwb_d.reg_write = exmem_p1.valid & exmem_p1.reg_write;
      memwb_d.data      = exmem_p1.result;
      if (mem_op) begin
         if (exmem_p1.oob) begin
            memwb_d.reg_write = 1'b0;
            memwb_d.data      = '0;
         end else if (exmem_p1.mem_write) begin
            memwb_d.reg_write = 1'b0;
         end else begin
            memwb_d.data = rdata;
         end
      end
   end

   // MEM -> WB boundary
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         memwb_p2 <= '0;
      else if (!stall)
         memwb_p2 <= memwb_d;
   end

   // Sticky fault: a new fault outranks a clear, and the address is only taken on a fresh fault
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault      <= 1'b0;
         fault_addr <= '0;
      end else if (!stall) begin
         if (fault_set) begin
            fault <= 1'b1;
            if (!fault || fault_clr) fault_addr <= exmem_p1.result;
         end else if (fault_clr) begin
            fault <= 1'b0;
         end
      end
   end

   assign mem_rd           = exmem_p1.rd;
   assign mem_reg_write    = exmem_p1.valid & exmem_p1.reg_write;
   assign mem_load_pending = exmem_p1.valid & exmem_p1.mem_read;
   assign wb_valid         = memwb_p2.valid;
   assign wb_reg_write     = memwb_p2.reg_write;
   assign wb_rd            = memwb_p2.rd;
   assign wb_data          = memwb_p2.data;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: stimulus pushes expected writeback
// entries, a monitor pops and compares whenever MEM/WB advances with a valid entry.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        ex_valid = 1'b0;
   logic [31:0] ex_result = '0;
   logic [31:0] ex_store_data = '0;
   logic [4:0]  ex_rd = '0;
   logic        ex_mem_read = 1'b0;
   logic        ex_mem_write = 1'b0;
   logic        ex_reg_write = 1'b0;
   logic        ex_oob = 1'b0;
   logic        fault_clr = 1'b0;
   logic [4:0]  mem_rd;
   logic        mem_reg_write;
   logic        mem_load_pending;
   logic        wb_valid;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        fault;
   logic [31:0] fault_addr;

   typedef struct {
      logic        rw;
      logic [4:0]  rd;
      logic [31:0] data;
      bit          chk_data;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   mem_access_stage dut (
      .clk              (clk),
      .rst              (rst),
      .stall            (stall),
      .flush            (flush),
      .ex_valid         (ex_valid),
      .ex_result        (ex_result),
      .ex_store_data    (ex_store_data),
      .ex_rd            (ex_rd),
      .ex_mem_read      (ex_mem_read),
      .ex_mem_write     (ex_mem_write),
      .ex_reg_write     (ex_reg_write),
      .ex_oob           (ex_oob),
      .fault_clr        (fault_clr),
      .mem_rd           (mem_rd),
      .mem_reg_write    (mem_reg_write),
      .mem_load_pending (mem_load_pending),
      .wb_valid         (wb_valid),
      .wb_reg_write     (wb_reg_write),
      .wb_rd            (wb_rd),
      .wb_data          (wb_data),
      .fault            (fault),
      .fault_addr       (fault_addr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic expect_wb(input logic rw, input logic [4:0] rd, input logic [31:0] d, input bit cd);
      exp_t e;
      e.rw = rw; e.rd = rd; e.data = d; e.chk_data = cd;
      exp_q.push_back(e);
   endtask

   // Present one EX slot, then wait for the capturing edge plus a small offset
   task automatic drive(input logic v, input logic [31:0] res, input logic [31:0] sd,
                        input logic [4:0] rd, input logic mr, input logic mw,
                        input logic rw, input logic oob);
      ex_valid = v; ex_result = res; ex_store_data = sd; ex_rd = rd;
      ex_mem_read = mr; ex_mem_write = mw; ex_reg_write = rw; ex_oob = oob;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic st(input logic [31:0] addr, input logic [31:0] d);
      expect_wb(1'b0, 5'd0, '0, 1'b0);
      drive(1'b1, addr, d, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic ld(input logic [31:0] addr, input logic [4:0] rd, input logic [31:0] exp);
      expect_wb(1'b1, rd, exp, 1'b1);
      drive(1'b1, addr, '0, rd, 1'b1, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_wb_valid"},         {31'd0, wb_valid},         32'd0);
      chk({tag, "_wb_reg_write"},     {31'd0, wb_reg_write},     32'd0);
      chk({tag, "_wb_rd"},            {27'd0, wb_rd},            32'd0);
      chk({tag, "_wb_data"},          wb_data,                   32'd0);
      chk({tag, "_mem_rd"},           {27'd0, mem_rd},           32'd0);
      chk({tag, "_mem_reg_write"},    {31'd0, mem_reg_write},    32'd0);
      chk({tag, "_mem_load_pending"}, {31'd0, mem_load_pending}, 32'd0);
      chk({tag, "_fault"},            {31'd0, fault},            32'd0);
      chk({tag, "_fault_addr"},       fault_addr,                32'd0);
   endtask

   // Monitor: MEM/WB advances on an edge without stall or reset
   initial begin
      logic adv;
      exp_t e;
      forever begin
         @(posedge clk);
         adv = !stall && !rst;
         @(negedge clk);
         if (adv && wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL wb_unexpected: got rd=%0d data=%h, expected no entry", wb_rd, wb_data);
            end else begin
               e = exp_q.pop_front();
               chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e.rw});
               chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
               if (e.chk_data) chk("wb_data", wb_data, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] sv_data;
      logic [4:0]  sv_rd;

      // Asynchronous reset before any clock edge
      #2 rst = 1'b1;
      #1 chk_reset("init");
      @(negedge clk) rst = 1'b0;
      idle();

      // Store then immediately load the same word
      st(32'd4, 32'hDEADBEEF);
      ld(32'd4, 5'd3, 32'hDEADBEEF);
      chk("load_pending", {31'd0, mem_load_pending}, 32'd1);
      chk("mem_rd_load", {27'd0, mem_rd}, 32'd3);
      // ALU passthrough
      expect_wb(1'b1, 5'd5, 32'h12345678, 1'b1);
      drive(1'b1, 32'h12345678, '0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("mem_reg_write_alu", {31'd0, mem_reg_write}, 32'd1);
      st(32'd252, 32'hCAFEF00D);

      // First fault: out-of-bound load at 300
      expect_wb(1'b0, 5'd6, 32'd0, 1'b1);
      drive(1'b1, 32'd300, '0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
      idle();
      chk("fault_first", {31'd0, fault}, 32'd1);
      chk("fault_addr_first", fault_addr, 32'd300);

      // Second fault (oob store, index 252) does not overwrite the address
      expect_wb(1'b0, 5'd0, 32'd0, 1'b1);
      drive(1'b1, 32'hFFFFFFFC, 32'hBADBAD00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      idle();
      chk("fault_addr_kept", fault_addr, 32'd300);

      // Clear alone
      fault_clr = 1'b1;
      idle();
      fault_clr = 1'b0;
      chk("fault_cleared", {31'd0, fault}, 32'd0);

      // Clear coinciding with a new fault (oob store at 260, index 4)
      expect_wb(1'b0, 5'd0, 32'd0, 1'b1);
      drive(1'b1, 32'd260, 32'h01010101, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      fault_clr = 1'b1;
      idle();
      fault_clr = 1'b0;
      chk("fault_set_wins", {31'd0, fault}, 32'd1);
      chk("fault_addr_new", fault_addr, 32'd260);

      // Suppressed stores left memory untouched
      ld(32'd252, 5'd7, 32'hCAFEF00D);
      ld(32'd4, 5'd8, 32'hDEADBEEF);

      // Stall three cycles with a store to 7 in EX/MEM
      st(32'd7, 32'h77777777);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h000000A5, '0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0);
         chk("stall_wb_rd", {27'd0, wb_rd}, 32'd8);
         chk("stall_wb_data", wb_data, 32'hDEADBEEF);
         chk("stall_mem_reg_write", {31'd0, mem_reg_write}, 32'd0);
      end
      stall = 1'b0;
      expect_wb(1'b1, 5'd9, 32'h000000A5, 1'b1);
      drive(1'b1, 32'h000000A5, '0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0);
      ld(32'd7, 5'd10, 32'h77777777);

      // Flushed store to 9 must not write
      st(32'd9, 32'h09090909);
      flush = 1'b1;
      drive(1'b1, 32'd9, 32'h99999999, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      flush = 1'b0;
      idle();
      chk("flush_wb_valid", {31'd0, wb_valid}, 32'd0);
      ld(32'd9, 5'd11, 32'h09090909);

      // Stall plus flush: EX/MEM squashed, MEM/WB holds
      drive(1'b1, 32'h0000000B, '0, 5'd12, 1'b0, 1'b0, 1'b1, 1'b0);
      sv_rd = wb_rd;
      sv_data = wb_data;
      stall = 1'b1;
      flush = 1'b1;
      drive(1'b1, 32'h0000000C, '0, 5'd13, 1'b0, 1'b0, 1'b1, 1'b0);
      stall = 1'b0;
      flush = 1'b0;
      chk("sf_wb_rd", {27'd0, wb_rd}, {27'd0, sv_rd});
      chk("sf_wb_rd_val", {27'd0, wb_rd}, 32'd11);
      chk("sf_wb_data", wb_data, sv_data);
      chk("sf_wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("sf_bubble", {31'd0, mem_reg_write}, 32'd0);
      idle();
      idle();

      // Reset between two stores
      st(32'd20, 32'h11111111);
      idle();
      idle();
      idle();
      expect_wb(1'b0, 5'd0, '0, 1'b0);
      drive(1'b1, 32'd21, 32'h22222222, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("pre_reset_mem_rd", {27'd0, mem_rd}, 32'd5);
      #1 rst = 1'b1;
      #1 chk_reset("midrst");
      exp_q.delete();
      @(negedge clk) rst = 1'b0;
      idle();
      ld(32'd20, 5'd14, 32'h11111111);
      idle();
      idle();
      idle();

      chk("queue_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
